// File: rtl/pim_cmd_sequencer_pkg.sv
// Shared definitions for the PIM command sequencer and its CFU link.
// Function codes are common with the CFU itself.
package pim_cmd_sequencer_pkg;

   localparam int DEF_DWIDTH = 32;
   localparam int DEF_AWIDTH = 10;
   localparam int DEF_MWIDTH = 8;

   localparam int FN_READ  = 0;
   localparam int FN_WRITE = 1;
   localparam int FN_MAC   = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WR_CMD,
      S_WR_RSP,
      S_MAC_CMD,
      S_MAC_RSP,
      S_DONE
   } state_t;

   // States in which a CFU command or its response is outstanding.
   function automatic logic is_wait_state(input state_t s);
      return (s == S_WR_CMD) || (s == S_WR_RSP) || (s == S_MAC_CMD) || (s == S_MAC_RSP);
   endfunction

endpackage

// File: rtl/pim_cmd_sequencer_if.sv
// CFU command/response link: master is the sequencer, slave is the CFU.
interface pim_cmd_sequencer_if
   import pim_cmd_sequencer_pkg::*;
#(
   parameter int DWIDTH = DEF_DWIDTH,
   parameter int AWIDTH = DEF_AWIDTH
);

   logic              cmd_valid;
   logic              cmd_ready;
   logic [AWIDTH-1:0] cmd_payload_function_id;
   logic [DWIDTH-1:0] cmd_payload_inputs_0;
   logic [DWIDTH-1:0] cmd_payload_inputs_1;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DWIDTH-1:0] rsp_payload_outputs_0;

   modport master (
      output cmd_valid,
      input  cmd_ready,
      output cmd_payload_function_id,
      output cmd_payload_inputs_0,
      output cmd_payload_inputs_1,
      input  rsp_valid,
      output rsp_ready,
      input  rsp_payload_outputs_0
   );

   modport slave (
      input  cmd_valid,
      output cmd_ready,
      input  cmd_payload_function_id,
      input  cmd_payload_inputs_0,
      input  cmd_payload_inputs_1,
      output rsp_valid,
      input  rsp_ready,
      output rsp_payload_outputs_0
   );

endinterface

// File: rtl/pim_cmd_sequencer_watchdog.sv
// Response watchdog: counts waiting cycles and flags when the budget is spent.
module pim_rsp_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic timeout
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] wait_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt <= '0;
      end else if (clear) begin
         wait_cnt <= '0;
      end else if (enable) begin
         wait_cnt <= wait_cnt + CW'(1);
      end
   end

   assign timeout = enable && (wait_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/pim_cmd_sequencer.sv
// Job-level front end for the PIM CFU: streams weight words in with write
// commands, then issues MAC commands and returns the final MAC response.
module pim_cmd_sequencer
   import pim_cmd_sequencer_pkg::*;
#(
   parameter int DWIDTH  = DEF_DWIDTH,
   parameter int AWIDTH  = DEF_AWIDTH,
   parameter int MWIDTH  = DEF_MWIDTH,
   parameter int LWIDTH  = 9,
   parameter int SWIDTH  = 5,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              job_valid,
   output logic              job_ready,
   input  logic [MWIDTH-1:0] job_base,
   input  logic [LWIDTH-1:0] job_len,
   input  logic [SWIDTH-1:0] job_steps,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   input  logic [DWIDTH-1:0] wdata,
   pim_cmd_sequencer_if.master cfu,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DWIDTH-1:0] res_data,
   output logic              res_err,
   output logic              busy
);

   state_t state_q, state_d;

   logic [MWIDTH-1:0] addr_q;
   logic [LWIDTH-1:0] len_q;
   logic [SWIDTH-1:0] step_q;
   logic [DWIDTH-1:0] word_q;
   logic [DWIDTH-1:0] res_data_q;
   logic              res_err_q;

   logic accept;
   logic load_word;
   logic write_done;
   logic mac_done;
   logic abort;
   logic wait_state;
   logic wd_clear;
   logic timeout;

   assign wait_state = is_wait_state(state_q);
   assign wd_clear   = write_done || mac_done || abort || !wait_state;

   pim_rsp_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (wd_clear),
      .enable  (wait_state),
      .timeout (timeout)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A response that arrives together with cmd_ready completes the command
   // on the spot, so the *_RSP state is only visited for late responses.
   always_comb begin
      state_d                     = state_q;
      job_ready                   = 1'b0;
      wdata_ready                 = 1'b0;
      cfu.cmd_valid               = 1'b0;
      cfu.cmd_payload_function_id = AWIDTH'(FN_READ);
      cfu.cmd_payload_inputs_0    = '0;
      cfu.cmd_payload_inputs_1    = '0;
      cfu.rsp_ready               = 1'b0;
      res_valid                   = 1'b0;
      accept                      = 1'b0;
      load_word                   = 1'b0;
      write_done                  = 1'b0;
      mac_done                    = 1'b0;
      abort                       = 1'b0;

      case (state_q)
         S_IDLE: begin
            job_ready = 1'b1;
            if (job_valid) begin
               accept = 1'b1;
               if (job_len != '0) begin
                  state_d = S_LOAD;
               end else if (job_steps != '0) begin
                  state_d = S_MAC_CMD;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_LOAD: begin
            wdata_ready = 1'b1;
            if (wdata_valid) begin
               load_word = 1'b1;
               state_d   = S_WR_CMD;
            end
         end
         S_WR_CMD: begin
            cfu.cmd_valid               = 1'b1;
            cfu.cmd_payload_function_id = AWIDTH'(FN_WRITE);
            cfu.cmd_payload_inputs_0    = word_q;
            cfu.cmd_payload_inputs_1    = DWIDTH'(addr_q);
            cfu.rsp_ready               = 1'b1;
            if (cfu.cmd_ready && cfu.rsp_valid) begin
               write_done = 1'b1;
            end else if (timeout) begin
               abort = 1'b1;
            end else if (cfu.cmd_ready) begin
               state_d = S_WR_RSP;
            end
         end
         S_WR_RSP: begin
            cfu.rsp_ready = 1'b1;
            if (cfu.rsp_valid) begin
               write_done = 1'b1;
            end else if (timeout) begin
               abort = 1'b1;
            end
         end
         S_MAC_CMD: begin
            cfu.cmd_valid               = 1'b1;
            cfu.cmd_payload_function_id = AWIDTH'(FN_MAC);
            cfu.rsp_ready               = 1'b1;
            if (cfu.cmd_ready && cfu.rsp_valid) begin
               mac_done = 1'b1;
            end else if (timeout) begin
               abort = 1'b1;
            end else if (cfu.cmd_ready) begin
               state_d = S_MAC_RSP;
            end
         end
         S_MAC_RSP: begin
            cfu.rsp_ready = 1'b1;
            if (cfu.rsp_valid) begin
               mac_done = 1'b1;
            end else if (timeout) begin
               abort = 1'b1;
            end
         end
         S_DONE: begin
            res_valid = 1'b1;
            if (res_ready) begin
               state_d = S_IDLE;
            end
         end
         default: ;
      endcase

      if (write_done) begin
         if (len_q == LWIDTH'(1)) begin
            state_d = (step_q == '0) ? S_DONE : S_MAC_CMD;
         end else begin
            state_d = S_LOAD;
         end
      end
      if (mac_done) begin
         state_d = (step_q == SWIDTH'(1)) ? S_DONE : S_MAC_CMD;
      end
      if (abort) begin
         state_d = S_DONE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q     <= '0;
         len_q      <= '0;
         step_q     <= '0;
         word_q     <= '0;
         res_data_q <= '0;
         res_err_q  <= 1'b0;
      end else begin
         if (accept) begin
            addr_q     <= job_base;
            len_q      <= job_len;
            step_q     <= job_steps;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
         end
         if (load_word) begin
            word_q <= wdata;
         end
         if (write_done) begin
            addr_q <= addr_q + MWIDTH'(1);
            len_q  <= len_q - LWIDTH'(1);
         end
         if (mac_done) begin
            step_q <= step_q - SWIDTH'(1);
            if (step_q == SWIDTH'(1)) begin
               res_data_q <= cfu.rsp_payload_outputs_0;
            end
         end
         if (abort) begin
            res_data_q <= '0;
            res_err_q  <= 1'b1;
         end
      end
   end

   assign res_data = res_data_q;
   assign res_err  = res_err_q;
   assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_pim_cmd_sequencer.sv
// Directed bench for pim_cmd_sequencer with a small CFU responder and command log.
module tb_pim_cmd_sequencer;
   import pim_cmd_sequencer_pkg::*;

   localparam int DW = 32;
   localparam int AW = 10;
   localparam int MW = 8;
   localparam int LW = 9;
   localparam int SW = 5;

   logic          clk;
   logic          reset;
   logic          job_valid;
   logic          job_ready;
   logic [MW-1:0] job_base;
   logic [LW-1:0] job_len;
   logic [SW-1:0] job_steps;
   logic          wdata_valid;
   logic          wdata_ready;
   logic [DW-1:0] wdata;
   logic          res_valid;
   logic          res_ready;
   logic [DW-1:0] res_data;
   logic          res_err;
   logic          busy;

   pim_cmd_sequencer_if #(.DWIDTH(DW), .AWIDTH(AW)) cfu();

   pim_cmd_sequencer #(
      .DWIDTH(DW), .AWIDTH(AW), .MWIDTH(MW), .LWIDTH(LW), .SWIDTH(SW), .TIMEOUT(64)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .job_valid   (job_valid),
      .job_ready   (job_ready),
      .job_base    (job_base),
      .job_len     (job_len),
      .job_steps   (job_steps),
      .wdata_valid (wdata_valid),
      .wdata_ready (wdata_ready),
      .wdata       (wdata),
      .cfu         (cfu),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .res_err     (res_err),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int err_cnt;
   int chk_cnt;

   // CFU model configuration, written only by the test tasks.
   int            stall_cycles;
   bit            never_rsp;
   bit            rsp_delay;
   logic [DW-1:0] rsp_base;
   logic [DW-1:0] feed_words [0:7];
   int            feed_cnt;

   // Observed traffic, written only by the monitor.
   int            n_cmd;
   int            n_mac;
   int            feed_idx;
   int            stall_seen;
   bit            rsp_pend;
   logic [AW-1:0] log_fn [0:15];
   logic [DW-1:0] log_d0 [0:15];
   logic [DW-1:0] log_d1 [0:15];

   always @(posedge clk) begin
      rsp_pend <= cfu.cmd_valid && cfu.cmd_ready;
      if (job_valid && job_ready) begin
         n_cmd      <= 0;
         n_mac      <= 0;
         feed_idx   <= 0;
         stall_seen <= 0;
      end else begin
         if (wdata_valid && wdata_ready) feed_idx <= feed_idx + 1;
         if (cfu.cmd_valid && cfu.cmd_ready) begin
            if (n_cmd < 16) begin
               log_fn[n_cmd] <= cfu.cmd_payload_function_id;
               log_d0[n_cmd] <= cfu.cmd_payload_inputs_0;
               log_d1[n_cmd] <= cfu.cmd_payload_inputs_1;
            end
            n_cmd      <= n_cmd + 1;
            stall_seen <= 0;
            if (cfu.cmd_payload_function_id == AW'(FN_MAC)) n_mac <= n_mac + 1;
         end else if (cfu.cmd_valid) begin
            stall_seen <= stall_seen + 1;
         end
      end
   end

   // Responses carry rsp_base + (MAC index, 1-based) so the final value is predictable.
   always @(negedge clk) begin
      cfu.cmd_ready = !(cfu.cmd_valid && (stall_seen < stall_cycles));
      cfu.rsp_valid = !never_rsp && (rsp_delay ? rsp_pend : (cfu.cmd_valid && cfu.cmd_ready));
      cfu.rsp_payload_outputs_0 = rsp_base + DW'(n_mac + (rsp_delay ? 0 : 1));
      wdata_valid = (feed_idx < feed_cnt);
      wdata       = feed_words[feed_idx & 7];
   end

   task automatic start_job(input logic [MW-1:0] b, input int len, input int steps);
      @(negedge clk);
      job_base  = b;
      job_len   = LW'(len);
      job_steps = SW'(steps);
      job_valid = 1'b1;
      @(negedge clk);
      job_valid = 1'b0;
   endtask

   task automatic wait_result(input int budget, output bit got, output int cycles);
      got    = 1'b0;
      cycles = 0;
      while (!got && cycles < budget) begin
         @(negedge clk);
         cycles++;
         if (res_valid) got = 1'b1;
      end
   endtask

   task automatic ack_result();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      chk_cnt++;
      if (job_ready !== 1'b1) begin
         err_cnt++; $display("[TB] FAIL reset_job_ready: got %b expected 1", job_ready);
      end
      chk_cnt++;
      if ({busy, res_valid, res_err, wdata_ready, cfu.cmd_valid, cfu.rsp_ready} !== 6'b0) begin
         err_cnt++;
         $display("[TB] FAIL reset_ctrl: got busy=%b res_valid=%b res_err=%b wdata_ready=%b cmd_valid=%b rsp_ready=%b expected all 0",
                  busy, res_valid, res_err, wdata_ready, cfu.cmd_valid, cfu.rsp_ready);
      end
      chk_cnt++;
      if (res_data !== 32'h0 || cfu.cmd_payload_inputs_0 !== 32'h0 || cfu.cmd_payload_function_id !== 10'h0) begin
         err_cnt++;
         $display("[TB] FAIL reset_data: got res_data=%h in0=%h fn=%h expected 0", res_data,
                  cfu.cmd_payload_inputs_0, cfu.cmd_payload_function_id);
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write_stream();
      bit got;
      int cyc;
      feed_words[0] = 32'hA1A1_0001;
      feed_words[1] = 32'hB2B2_0002;
      feed_words[2] = 32'hC3C3_0003;
      feed_cnt = 3;
      start_job(8'h10, 3, 0);
      wait_result(100, got, cyc);
      chk_cnt++;
      if (!got) begin
         err_cnt++; $display("[TB] FAIL stream_done: got no res_valid expected res_valid within 100 cycles");
      end
      chk_cnt++;
      if (n_cmd !== 3) begin
         err_cnt++; $display("[TB] FAIL stream_cmd_count: got %0d expected 3", n_cmd);
      end
      for (int i = 0; i < 3; i++) begin
         chk_cnt++;
         if (log_fn[i] !== 10'd1 || log_d0[i] !== feed_words[i] || log_d1[i] !== DW'(16 + i)) begin
            err_cnt++;
            $display("[TB] FAIL stream_cmd%0d: got fn=%0d d0=%h d1=%h expected fn=1 d0=%h d1=%h",
                     i, log_fn[i], log_d0[i], log_d1[i], feed_words[i], DW'(16 + i));
         end
      end
      chk_cnt++;
      if (res_data !== 32'h0 || res_err !== 1'b0) begin
         err_cnt++; $display("[TB] FAIL stream_result: got data=%h err=%b expected data=0 err=0", res_data, res_err);
      end
      ack_result();
   endtask

   task automatic test_wrap();
      bit got;
      int cyc;
      feed_words[0] = 32'h0000_00EE;
      feed_words[1] = 32'h0000_00DD;
      feed_cnt = 2;
      start_job(8'hFF, 2, 0);
      wait_result(100, got, cyc);
      chk_cnt++;
      if (!got || n_cmd !== 2) begin
         err_cnt++; $display("[TB] FAIL wrap_done: got done=%b cmds=%0d expected done=1 cmds=2", got, n_cmd);
      end
      chk_cnt++;
      if (log_d1[0] !== 32'hFF || log_d1[1] !== 32'h00) begin
         err_cnt++; $display("[TB] FAIL wrap_addr: got %h,%h expected 000000ff,00000000", log_d1[0], log_d1[1]);
      end
      ack_result();
   endtask

   task automatic test_mac();
      bit got;
      int cyc;
      feed_cnt = 0;
      rsp_base = 32'd4;
      start_job(8'h00, 0, 4);
      wait_result(100, got, cyc);
      chk_cnt++;
      if (!got || n_cmd !== 4 || n_mac !== 4) begin
         err_cnt++; $display("[TB] FAIL mac_count: got done=%b cmds=%0d macs=%0d expected done=1 cmds=4 macs=4", got, n_cmd, n_mac);
      end
      for (int i = 0; i < 4; i++) begin
         chk_cnt++;
         if (log_fn[i] !== 10'd2 || log_d0[i] !== 32'h0 || log_d1[i] !== 32'h0) begin
            err_cnt++;
            $display("[TB] FAIL mac_cmd%0d: got fn=%0d d0=%h d1=%h expected fn=2 d0=0 d1=0", i, log_fn[i], log_d0[i], log_d1[i]);
         end
      end
      chk_cnt++;
      if (res_data !== 32'd8 || res_err !== 1'b0) begin
         err_cnt++; $display("[TB] FAIL mac_result: got data=%h err=%b expected data=8 err=0", res_data, res_err);
      end
      @(negedge clk);
      chk_cnt++;
      if (res_valid !== 1'b1 || res_data !== 32'd8) begin
         err_cnt++; $display("[TB] FAIL mac_hold: got valid=%b data=%h expected valid=1 data=8", res_valid, res_data);
      end
      ack_result();
      rsp_base = 32'd0;
   endtask

   task automatic test_stall();
      bit got;
      int cyc;
      int waited;
      feed_words[0] = 32'h5A5A_1234;
      feed_cnt      = 1;
      stall_cycles  = 3;
      start_job(8'h20, 1, 0);
      waited = 0;
      while (cfu.cmd_valid !== 1'b1 && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      // Three stalled cycles plus the accepting one must all show the same command.
      for (int i = 0; i < 4; i++) begin
         chk_cnt++;
         if (cfu.cmd_valid !== 1'b1 || cfu.cmd_payload_function_id !== 10'd1 ||
             cfu.cmd_payload_inputs_0 !== 32'h5A5A_1234 || cfu.cmd_payload_inputs_1 !== 32'h20 ||
             wdata_ready !== 1'b0 || cfu.rsp_ready !== 1'b1) begin
            err_cnt++;
            $display("[TB] FAIL stall_hold%0d: got valid=%b fn=%0d d0=%h d1=%h wrdy=%b rrdy=%b expected 1,1,5a5a1234,20,0,1",
                     i, cfu.cmd_valid, cfu.cmd_payload_function_id, cfu.cmd_payload_inputs_0,
                     cfu.cmd_payload_inputs_1, wdata_ready, cfu.rsp_ready);
         end
         if (i < 3) @(negedge clk);
      end
      wait_result(50, got, cyc);
      chk_cnt++;
      if (!got || n_cmd !== 1) begin
         err_cnt++; $display("[TB] FAIL stall_single: got done=%b cmds=%0d expected done=1 cmds=1", got, n_cmd);
      end
      ack_result();
      stall_cycles = 0;
   endtask

   task automatic test_timeout();
      bit got;
      int cyc;
      feed_cnt  = 0;
      never_rsp = 1'b1;
      start_job(8'h00, 0, 1);
      wait_result(100, got, cyc);
      chk_cnt++;
      if (!got || cyc !== 64) begin
         err_cnt++; $display("[TB] FAIL timeout_latency: got done=%b cycles=%0d expected done=1 cycles=64", got, cyc);
      end
      chk_cnt++;
      if (res_err !== 1'b1 || res_data !== 32'h0 || cfu.cmd_valid !== 1'b0) begin
         err_cnt++;
         $display("[TB] FAIL timeout_abort: got err=%b data=%h cmd_valid=%b expected err=1 data=0 cmd_valid=0",
                  res_err, res_data, cfu.cmd_valid);
      end
      ack_result();
      never_rsp     = 1'b0;
      rsp_base      = 32'h100;
      feed_words[0] = 32'h0000_0077;
      feed_cnt      = 1;
      start_job(8'h40, 1, 1);
      wait_result(100, got, cyc);
      chk_cnt++;
      if (!got || res_err !== 1'b0 || res_data !== 32'h101) begin
         err_cnt++;
         $display("[TB] FAIL timeout_recover: got done=%b err=%b data=%h expected done=1 err=0 data=101", got, res_err, res_data);
      end
      ack_result();
      rsp_base = 32'd0;
   endtask

   task automatic test_reset_mid();
      bit got;
      bit hit;
      int cyc;
      feed_cnt  = 0;
      rsp_delay = 1'b1;
      start_job(8'h00, 0, 4);
      hit = 1'b0;
      for (int i = 0; i < 50 && !hit; i++) begin
         @(negedge clk);
         if (n_mac == 2 && cfu.cmd_valid === 1'b0 && busy === 1'b1 && res_valid === 1'b0) hit = 1'b1;
      end
      chk_cnt++;
      if (!hit) begin
         err_cnt++; $display("[TB] FAIL midreset_reach: got no MAC_RSP of step 2 expected it within 50 cycles");
      end
      reset = 1'b0;
      #1;
      chk_cnt++;
      if (job_ready !== 1'b1 || busy !== 1'b0 || cfu.cmd_valid !== 1'b0 || cfu.rsp_ready !== 1'b0 ||
          res_valid !== 1'b0 || res_err !== 1'b0 || res_data !== 32'h0 || wdata_ready !== 1'b0) begin
         err_cnt++;
         $display("[TB] FAIL midreset_outputs: got jrdy=%b busy=%b cv=%b rr=%b rv=%b err=%b data=%h wr=%b expected 1,0,0,0,0,0,0,0",
                  job_ready, busy, cfu.cmd_valid, cfu.rsp_ready, res_valid, res_err, res_data, wdata_ready);
      end
      @(negedge clk);
      reset     = 1'b1;
      rsp_delay = 1'b0;
      @(negedge clk);
      rsp_base      = 32'h20;
      feed_words[0] = 32'hCAFE_0001;
      feed_cnt      = 1;
      start_job(8'h30, 1, 2);
      wait_result(100, got, cyc);
      chk_cnt++;
      if (!got || n_cmd !== 3 || log_fn[0] !== 10'd1 || log_d1[0] !== 32'h30) begin
         err_cnt++;
         $display("[TB] FAIL midreset_rerun_cmds: got done=%b cmds=%0d fn0=%0d addr0=%h expected done=1 cmds=3 fn0=1 addr0=30",
                  got, n_cmd, log_fn[0], log_d1[0]);
      end
      chk_cnt++;
      if (res_data !== 32'h22 || res_err !== 1'b0) begin
         err_cnt++; $display("[TB] FAIL midreset_rerun_result: got data=%h err=%b expected data=22 err=0", res_data, res_err);
      end
      ack_result();
   endtask

   initial begin
      err_cnt      = 0;
      chk_cnt      = 0;
      stall_cycles = 0;
      never_rsp    = 1'b0;
      rsp_delay    = 1'b0;
      rsp_base     = '0;
      feed_cnt     = 0;
      for (int i = 0; i < 8; i++) feed_words[i] = '0;
      reset        = 1'b0;
      job_valid    = 1'b0;
      job_base     = '0;
      job_len      = '0;
      job_steps    = '0;
      res_ready    = 1'b0;

      test_reset();
      test_write_stream();
      test_wrap();
      test_mac();
      test_stall();
      test_timeout();
      test_reset_mid();

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
